// File: rtl/sensor_module.sv
// Behavioural analog sensor front-end: quantises a real-valued environment
// input to an unsigned WIDTH-bit code, with optional block averaging.
module sensor_module #(
    parameter int  WIDTH      = 8,
    parameter real FULL_SCALE = 1.0,
    parameter int  AVG_LOG2   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  real              environment,
    input  logic             enable,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             sat
);

    localparam int  ACC_W = WIDTH + AVG_LOG2;
    localparam int  CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam real MAX_R = (2.0 ** WIDTH) - 1.0;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << AVG_LOG2) - 1);

    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_stk;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_sat;

    real              w_scaled;
    logic [WIDTH-1:0] w_code;
    logic             w_clip;
    logic [ACC_W-1:0] w_sum;
    logic             w_last;

    // Range checks are done on the real value so out-of-range inputs never
    // reach the integer conversion.
    always_comb begin
        w_scaled = $floor(environment / FULL_SCALE * MAX_R + 0.5);
        w_code   = '0;
        w_clip   = 1'b0;
        if (environment != environment) begin
            w_clip = 1'b1;
        end else if (w_scaled < 0.0) begin
            w_clip = 1'b1;
        end else if (w_scaled > MAX_R) begin
            w_code = '1;
            w_clip = 1'b1;
        end else begin
            w_code = WIDTH'($rtoi(w_scaled));
        end
    end

    // With AVG_LOG2 = 0 the counter stays at 0, which equals LAST_CNT.
    assign w_sum  = r_acc + ACC_W'(w_code);
    assign w_last = (r_cnt == LAST_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_stk   <= 1'b0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_sat   <= 1'b0;
        end else if (enable) begin
            if (w_last) begin
                r_data  <= WIDTH'(w_sum >> AVG_LOG2);
                r_sat   <= r_stk | w_clip;
                r_valid <= 1'b1;
                r_acc   <= '0;
                r_cnt   <= '0;
                r_stk   <= 1'b0;
            end else begin
                r_acc   <= w_sum;
                r_cnt   <= r_cnt + 1'b1;
                r_stk   <= r_stk | w_clip;
                r_valid <= 1'b0;
            end
        end else begin
            // Partial block is dropped; outputs other than valid hold.
            r_valid <= 1'b0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_stk   <= 1'b0;
        end
    end

    assign data  = r_data;
    assign valid = r_valid;
    assign sat   = r_sat;

endmodule

// File: tb/tb_sensor_module.sv
// Directed bench for sensor_module: one instance without averaging, one
// averaging blocks of four samples.
module tb_sensor_module;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    real        env0 = 0.0;
    real        env2 = 0.0;
    logic       en0 = 1'b0;
    logic       en2 = 1'b0;
    logic [7:0] data0, data2;
    logic       valid0, valid2, sat0, sat2;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sensor_module #(.WIDTH(8), .FULL_SCALE(1.0), .AVG_LOG2(0)) u_dut0 (
        .clk(clk), .rst(rst), .environment(env0), .enable(en0),
        .data(data0), .valid(valid0), .sat(sat0)
    );

    sensor_module #(.WIDTH(8), .FULL_SCALE(1.0), .AVG_LOG2(2)) u_dut2 (
        .clk(clk), .rst(rst), .environment(env2), .enable(en2),
        .data(data2), .valid(valid2), .sat(sat2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    real        ramp_v [5] = '{0.0, 0.25, 0.5, 0.75, 1.0};
    logic [7:0] ramp_c [5] = '{8'h00, 8'h40, 8'h80, 8'hBF, 8'hFF};

    initial begin
        // reset state while rst is held
        repeat (2) step();
        chk("rst_data0", data0, 0);
        chk("rst_valid0", valid0, 0);
        chk("rst_sat0", sat0, 0);
        chk("rst_data2", data2, 0);
        chk("rst_valid2", valid2, 0);
        rst = 1'b0;
        step();

        // ramp, no averaging
        for (int i = 0; i < 5; i++) begin
            env0 = ramp_v[i];
            en0  = 1'b1;
            step();
            chk($sformatf("ramp_data%0d", i), data0, ramp_c[i]);
            chk($sformatf("ramp_valid%0d", i), valid0, 1);
            chk($sformatf("ramp_sat%0d", i), sat0, 0);
        end

        // disable holds data
        en0 = 1'b0;
        env0 = 0.5;
        step();
        chk("hold_data", data0, 8'hFF);
        chk("hold_valid", valid0, 0);
        chk("hold_sat", sat0, 0);

        // clipping
        en0 = 1'b1;
        env0 = 1.7;
        step();
        chk("clip_hi_data", data0, 8'hFF);
        chk("clip_hi_sat", sat0, 1);
        chk("clip_hi_valid", valid0, 1);
        env0 = -0.3;
        step();
        chk("clip_lo_data", data0, 8'h00);
        chk("clip_lo_sat", sat0, 1);
        env0 = 0.5;
        step();
        chk("unclip_data", data0, 8'h80);
        chk("unclip_sat", sat0, 0);
        en0 = 1'b0;

        // averaging over four samples
        for (int i = 0; i < 4; i++) begin
            env2 = ramp_v[i];
            en2  = 1'b1;
            step();
            if (i < 3) begin
                chk($sformatf("avg_novalid%0d", i), valid2, 0);
                chk($sformatf("avg_data_held%0d", i), data2, 0);
            end
        end
        chk("avg_valid", valid2, 1);
        chk("avg_data", data2, 8'h5F);
        chk("avg_sat", sat2, 0);

        // partial block abort
        env2 = 0.5;
        repeat (2) begin
            step();
            chk("part_novalid", valid2, 0);
        end
        en2 = 1'b0;
        step();
        chk("abort_valid", valid2, 0);
        chk("abort_data", data2, 8'h5F);
        en2 = 1'b1;
        env2 = 1.0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("restart_novalid%0d", i), valid2, 0);
            chk($sformatf("restart_data_held%0d", i), data2, 8'h5F);
        end
        step();
        chk("restart_valid", valid2, 1);
        chk("restart_data", data2, 8'hFF);

        // dut2 mid-block (two samples) while dut0 reaches 0xBF
        en0 = 1'b1;
        env0 = 0.75;
        env2 = 1.0;
        step();
        chk("pre_rst_data0", data0, 8'hBF);
        chk("pre_rst_valid2", valid2, 0);
        step();
        chk("pre_rst_valid2b", valid2, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_data0", data0, 0);
        chk("async_valid0", valid0, 0);
        chk("async_sat0", sat0, 0);
        chk("async_data2", data2, 0);
        en0 = 1'b0;
        en2 = 1'b0;
        step();
        chk("rst_held_data0", data0, 0);
        rst = 1'b0;

        // new block after reset starts at sample 1
        env2 = 0.25;
        en2  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("post_rst_novalid%0d", i), valid2, 0);
        end
        step();
        chk("post_rst_valid", valid2, 1);
        chk("post_rst_data", data2, 8'h40);
        en2 = 1'b0;
        step();
        chk("post_rst_pulse", valid2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/sensor_module.md
# sensor_module

Behavioural front-end model of an analog sensor with an 8-bit ADC. It samples a real-valued environment quantity on enabled clock edges, quantises it to an unsigned code and presents it as registered sensor data. The sensor node's data path consumes this code, qualified by a one-cycle valid strobe. Optional block averaging reduces noise.

## Interface
- WIDTH, 8: output code width in bits; full-scale code is 2^WIDTH-1.
- FULL_SCALE, 1.0 (real): environment value that maps to the full-scale code.
- AVG_LOG2, 0: log2 of the number of enabled samples averaged per output; 0 means no averaging.

- clk  input  1  rising-edge clock for all state.
- rst  input  1  reset, asynchronous, active-high; clears all state.
- environment  input  real  analog quantity being sensed, in the same units as FULL_SCALE.
- enable  input  1  sampling enable, evaluated on each rising clk edge.
- data  output  WIDTH  registered quantised code, unsigned.
- valid  output  1  one-cycle pulse when data is updated.
- sat  output  1  registered with data; high when the reported result included a clipped or invalid sample.

## Operation
- Quantiser, per sample:
  - code = floor(environment / FULL_SCALE * (2^WIDTH-1) + 0.5).
  - If the result is below 0, code = 0 and the sample is marked clipped.
  - If the result is above 2^WIDTH-1, code = 2^WIDTH-1 and the sample is marked clipped.
  - NaN input gives code 0, marked clipped.
- Reference codes with FULL_SCALE = 1.0 and WIDTH = 8: 0.0→0x00, 0.25→0x40, 0.5→0x80, 0.75→0xBF, 1.0→0xFF.
- Accumulator:
  - Width WIDTH+AVG_LOG2, plus a sample counter of AVG_LOG2 bits.
  - A sticky clip flag is carried with the accumulator.
- Enabled edge (enable=1):
  - Add the current code to the accumulator and OR the clip mark into the sticky flag.
  - When this sample completes a block of 2^AVG_LOG2 samples: data ← accumulator sum >> AVG_LOG2 (truncating), sat ← sticky flag, valid ← 1. The accumulator, counter and sticky flag are then cleared.
  - With AVG_LOG2 = 0, every enabled edge completes a block.
- Disabled edge (enable=0):
  - valid ← 0; data and sat hold their last values.
  - The partial block is discarded: accumulator, counter and sticky flag are cleared.
- environment is sampled only at the rising clk edge. Changes between edges have no effect.

## Timing
- Reset (rst=1, asynchronous): data=0, valid=0, sat=0; accumulator, counter and sticky flag are cleared. Outputs stay at these values while rst is high.
- First enabled edge after rst deasserts is sample 1 of a new block.
- Latency, AVG_LOG2=0: data and valid update at the same edge that samples environment, i.e. they are visible one clock after environment is set up.
- Latency, AVG_LOG2=N: output appears on the 2^N-th consecutive enabled edge.
- valid is high for exactly one cycle per completed block. With AVG_LOG2=0 and enable held high, valid stays high continuously and data changes every cycle.
- enable falling mid-block: no output is produced for the partial block, and valid is 0 on that edge.
- enable rising again: counting restarts from sample 1.
- rst asserted mid-block: the block is aborted immediately and outputs go to their reset values without waiting for a clock edge.

## Test plan
- Ramp, AVG_LOG2=0: rst pulse, then enable=1 while environment steps 0.0, 0.25, 0.5, 0.75, 1.0, one edge each -> data = 0x00, 0x40, 0x80, 0xBF, 0xFF on successive edges; valid=1 and sat=0 throughout.
- Disable hold: after data=0xFF, set enable=0 and environment=0.5 -> data stays 0xFF, valid=0, sat unchanged.
- Clipping: environment = 1.7, then -0.3, with enable=1 -> data=0xFF with sat=1, then data=0x00 with sat=1. Then environment=0.5 -> data=0x80, sat=0.
- Averaging, AVG_LOG2=2: four enabled samples 0.0, 0.25, 0.5, 0.75 -> a single valid pulse on the 4th edge with data=(0+64+128+191)>>2=0x5F. Valid is 0 on edges 1–3.
- Partial-block abort, AVG_LOG2=2: two enabled samples, enable=0 for one edge, then four samples of 1.0 -> no valid until the 4th of the new samples, then data=0xFF.
- Async reset: assert rst between clock edges while data=0xBF -> data=0, valid=0 and sat=0 before the next edge. The first enabled sample after rst deasserts starts a new block.
